// File: rtl/ifmap_stream_feeder.sv
// ifmap_stream_feeder: reads a rectangular tile of raw IFMap words from a
// synchronous-read memory and pushes them, tagged with start-of-row (MSB) and
// end-of-row (MSB-1) bits, into the PE IFMap input FIFO.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               launch a tile (sampled in IDLE only)
//   base_addr           address of the first word (sampled with start)
//   row_len, num_rows   tile shape (sampled with start)
//   mem_addr, mem_ren   memory read request; data returns one cycle later
//   mem_rdata           memory read data
//   buf_ready           FIFO can accept a word this cycle
//   IFMap_in            tagged word {sor, eor, payload} (skid head)
//   wen_IFMap_buffer    FIFO write strobe
//   busy                tile in progress
//   done                one-cycle pulse after the last word is written
module ifmap_stream_feeder #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ROW_LEN_SIZE = 8,
  parameter int unsigned ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ROW_LEN_SIZE-1:0] row_len,
  input  logic [ROW_LEN_SIZE-1:0] num_rows,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_ren,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    buf_ready,
  output logic [DATA_WIDTH+1:0]   IFMap_in,
  output logic                    wen_IFMap_buffer,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_next;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ROW_LEN_SIZE-1:0] row_len_q;
  logic [ROW_LEN_SIZE-1:0] num_rows_q;
  logic [ROW_LEN_SIZE-1:0] col_q;
  logic [ROW_LEN_SIZE-1:0] row_q;

  // One read may be in flight; its row-position tags travel alongside it.
  logic                    inflight_q;
  logic                    inflight_sor_q;
  logic                    inflight_eor_q;

  // Two-entry FIFO skid buffer holding returned, tagged words.
  logic [WORD_WIDTH-1:0]   skid_mem [2];
  logic                    skid_rd_ptr_q;
  logic                    skid_wr_ptr_q;
  logic [1:0]              skid_count_q;

  logic                    busy_q;
  logic                    done_q;

  logic                    pop_c;
  logic                    issue_c;
  logic                    last_col_c;
  logic                    last_row_c;
  logic                    last_issue_c;
  logic [2:0]              occupancy_c;

  // Issue/pop decisions and row-position decode.
  always_comb begin
    pop_c        = (skid_count_q != 2'd0) && buf_ready;
    occupancy_c  = 3'(skid_count_q) + 3'(inflight_q);
    // A pop this cycle frees the slot a new read will eventually need.
    issue_c      = (state_q == S_RUN) &&
                   ((occupancy_c < 3'd2) || ((occupancy_c == 3'd2) && pop_c));
    last_col_c   = (col_q == row_len_q - ROW_LEN_SIZE'(1));
    last_row_c   = (row_q == num_rows_q - ROW_LEN_SIZE'(1));
    last_issue_c = issue_c && last_col_c && last_row_c;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((row_len == '0) || (num_rows == '0)) state_next = S_DONE;
          else                                      state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_issue_c) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once the final word is being written this cycle.
        if (!inflight_q &&
            ((skid_count_q == 2'd0) || ((skid_count_q == 2'd1) && pop_c)))
          state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, counters, in-flight tracking and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      row_len_q      <= '0;
      num_rows_q     <= '0;
      col_q          <= '0;
      row_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_sor_q <= 1'b0;
      inflight_eor_q <= 1'b0;
      for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
      skid_rd_ptr_q  <= 1'b0;
      skid_wr_ptr_q  <= 1'b0;
      skid_count_q   <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q <= state_next;
      busy_q  <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done_q  <= (state_next == S_DONE);

      if ((state_q == S_IDLE) && start) begin
        addr_q     <= base_addr;
        row_len_q  <= row_len;
        num_rows_q <= num_rows;
        col_q      <= '0;
        row_q      <= '0;
      end else if (issue_c) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (last_col_c) begin
          col_q <= '0;
          row_q <= row_q + ROW_LEN_SIZE'(1);
        end else begin
          col_q <= col_q + ROW_LEN_SIZE'(1);
        end
      end

      inflight_q     <= issue_c;
      inflight_sor_q <= (col_q == '0);
      inflight_eor_q <= last_col_c;

      if (inflight_q) begin
        skid_mem[skid_wr_ptr_q] <= {inflight_sor_q, inflight_eor_q, mem_rdata};
        skid_wr_ptr_q           <= ~skid_wr_ptr_q;
      end
      if (pop_c) skid_rd_ptr_q <= ~skid_rd_ptr_q;

      case ({inflight_q, pop_c})
        2'b10:   skid_count_q <= skid_count_q + 2'd1;
        2'b01:   skid_count_q <= skid_count_q - 2'd1;
        default: skid_count_q <= skid_count_q;
      endcase
    end
  end

  assign mem_addr         = addr_q;
  assign mem_ren          = issue_c;
  assign wen_IFMap_buffer = pop_c;
  assign IFMap_in         = (skid_count_q != 2'd0) ? skid_mem[skid_rd_ptr_q] : '0;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// Directed bench for ifmap_stream_feeder: drives tiles cycle by cycle,
// records reads/writes and compares against hand-computed values.
module tb_ifmap_stream_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 8;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [RW-1:0] row_len;
  logic [RW-1:0] num_rows;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic          buf_ready;
  logic [DW+1:0] IFMap_in;
  logic          wen_IFMap_buffer;
  logic          busy;
  logic          done;

  ifmap_stream_feeder #(.DATA_WIDTH(DW), .ROW_LEN_SIZE(RW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .row_len          (row_len),
    .num_rows         (num_rows),
    .mem_addr         (mem_addr),
    .mem_ren          (mem_ren),
    .mem_rdata        (mem_rdata),
    .buf_ready        (buf_ready),
    .IFMap_in         (IFMap_in),
    .wen_IFMap_buffer (wen_IFMap_buffer),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Memory model: memory[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= DW'(mem_addr);
    else         mem_rdata <= 16'hDEAD;
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] wq[$];
  int          wc[$];
  logic [31:0] rq[$];
  int          rc[$];
  int          done_cyc;
  int          done_cnt;
  int          busy_at_done;
  int          busy_seen;
  int          wen_low;
  int          max_occ;
  int          n_rd;
  int          n_wr;
  int          start_cyc;
  logic [15:0] pat = 16'b0101_0011_0110_1001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    wq.delete(); wc.delete(); rq.delete(); rc.delete();
    done_cyc = -1; done_cnt = 0; busy_at_done = -1; busy_seen = 0;
    wen_low = 0; max_occ = 0; n_rd = 0; n_wr = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample shortly after.
  task automatic tick(input logic r, input logic s, input logic rdy);
    int occ;
    @(negedge clk);
    rst = r;
    start = s;
    buf_ready = rdy;
    #2;
    cyc++;
    if (mem_ren) begin rq.push_back(32'(mem_addr)); rc.push_back(cyc); n_rd++; end
    if (wen_IFMap_buffer) begin
      wq.push_back(32'(IFMap_in)); wc.push_back(cyc); n_wr++;
      if (!buf_ready) wen_low++;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = int'(busy); end
    end
    if (busy) busy_seen = 1;
    occ = n_rd - n_wr;
    if (occ > max_occ) max_occ = occ;
  endtask

  task automatic run_tile(input logic [AW-1:0] b, input logic [RW-1:0] rl,
                          input logic [RW-1:0] nr, input logic bp);
    clear_rec();
    base_addr = b; row_len = rl; num_rows = nr;
    tick(1'b0, 1'b1, bp ? pat[0] : 1'b1);
    start_cyc = cyc;
    for (int i = 1; i < 200; i++) begin
      tick(1'b0, 1'b0, bp ? pat[4'(i)] : 1'b1);
      if (done_cyc >= 0) break;
    end
    check("tile_done_seen", 32'(done_cyc >= 0), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    check("done_single_pulse", 32'(done_cnt), 32'd1);
  endtask

  function automatic logic [31:0] wget(input int k);
    return (k < wq.size()) ? wq[k] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rget(input int k);
    return (k < rq.size()) ? rq[k] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; buf_ready = 1'b0;
    base_addr = '0; row_len = '0; num_rows = '0;
    clear_rec();

    // Reset state
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_ren", 32'(mem_ren), 32'h0);
    check("rst_ifmap_in", 32'(IFMap_in), 32'h0);
    check("rst_wen", 32'(wen_IFMap_buffer), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Tile 4x2 at 0x10, no back-pressure
    run_tile(16'h0010, 8'd4, 8'd2, 1'b0);
    check("t1_nwrites", 32'(wq.size()), 32'd8);
    check("t1_w0", wget(0), 32'h20010);
    check("t1_w1", wget(1), 32'h00011);
    check("t1_w2", wget(2), 32'h00012);
    check("t1_w3", wget(3), 32'h10013);
    check("t1_w4", wget(4), 32'h20014);
    check("t1_w5", wget(5), 32'h00015);
    check("t1_w6", wget(6), 32'h00016);
    check("t1_w7", wget(7), 32'h10017);
    check("t1_first_read_cyc", (rc.size() > 0) ? 32'(rc[0]) : 32'hFFFF_FFFF, 32'(start_cyc + 1));
    check("t1_first_read_addr", rget(0), 32'h0010);
    check("t1_first_write_cyc", (wc.size() > 0) ? 32'(wc[0]) : 32'hFFFF_FFFF, 32'(start_cyc + 3));
    check("t1_last_write_cyc", (wc.size() > 7) ? 32'(wc[7]) : 32'hFFFF_FFFF, 32'(start_cyc + 10));
    check("t1_done_cyc", 32'(done_cyc), 32'(start_cyc + 11));
    check("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    check("t1_max_occ", 32'(max_occ <= 2), 32'd1);

    // Same tile with pseudo-random back-pressure
    run_tile(16'h0010, 8'd4, 8'd2, 1'b1);
    check("t2_nwrites", 32'(wq.size()), 32'd8);
    check("t2_w0", wget(0), 32'h20010);
    check("t2_w2", wget(2), 32'h00012);
    check("t2_w3", wget(3), 32'h10013);
    check("t2_w4", wget(4), 32'h20014);
    check("t2_w6", wget(6), 32'h00016);
    check("t2_w7", wget(7), 32'h10017);
    check("t2_wen_while_low", 32'(wen_low), 32'd0);
    check("t2_max_occ", 32'(max_occ <= 2), 32'd1);
    check("t2_nreads", 32'(rq.size()), 32'd8);

    // row_len = 1: every word tagged both ends
    run_tile(16'h0040, 8'd1, 8'd3, 1'b0);
    check("t3_nwrites", 32'(wq.size()), 32'd3);
    check("t3_w0", wget(0), 32'h30040);
    check("t3_w1", wget(1), 32'h30041);
    check("t3_w2", wget(2), 32'h30042);

    // Empty tile
    run_tile(16'h0080, 8'd0, 8'd5, 1'b0);
    check("t4_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));
    check("t4_nreads", 32'(rq.size()), 32'd0);
    check("t4_nwrites", 32'(wq.size()), 32'd0);
    check("t4_busy_seen", 32'(busy_seen), 32'd0);

    // Address wrap
    run_tile(16'hFFFE, 8'd4, 8'd1, 1'b0);
    check("t5_a0", rget(0), 32'hFFFE);
    check("t5_a1", rget(1), 32'hFFFF);
    check("t5_a2", rget(2), 32'h0000);
    check("t5_a3", rget(3), 32'h0001);
    check("t5_w0", wget(0), 32'h2FFFE);
    check("t5_w2", wget(2), 32'h00000);
    check("t5_w3", wget(3), 32'h10001);

    // Reset mid-tile with two words buffered and FIFO stalled
    clear_rec();
    base_addr = 16'h0100; row_len = 8'd4; num_rows = 8'd2;
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    check("t6_head_held", 32'(IFMap_in), 32'h20100);
    check("t6_reads_before_rst", 32'(rq.size()), 32'd2);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("t6_mem_addr", 32'(mem_addr), 32'h0);
    check("t6_mem_ren", 32'(mem_ren), 32'h0);
    check("t6_ifmap_in", 32'(IFMap_in), 32'h0);
    check("t6_wen", 32'(wen_IFMap_buffer), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_done", 32'(done), 32'h0);
    check("t6_no_writes", 32'(wq.size()), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    run_tile(16'h0200, 8'd2, 8'd2, 1'b0);
    check("t7_nwrites", 32'(wq.size()), 32'd4);
    check("t7_w0", wget(0), 32'h20200);
    check("t7_w1", wget(1), 32'h10201);
    check("t7_w2", wget(2), 32'h20202);
    check("t7_w3", wget(3), 32'h10203);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmap_stream_feeder.md
# ifmap_stream_feeder

Producer side of the PE input-feature-map stream. Reads a rectangular tile of raw IFMap words from a synchronous-read memory and pushes them into the PE's IFMap input FIFO. Each pushed word carries two tag bits: start-of-row at the MSB, end-of-row just below it. The PE read controller latches row bounds from those bits. The block honours FIFO back-pressure with a 2-entry skid buffer and sustains one word per cycle when the FIFO never stalls.

## Interface
- DATA_WIDTH, 16: payload bits per word. Equals the PE's IFMAP_WIDTH-2.
- ROW_LEN_SIZE, 8: width of the row_len and num_rows configuration inputs.
- ADDR_WIDTH, 16: memory address width.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  launches a tile when sampled high in IDLE; ignored otherwise.
- base_addr  in  ADDR_WIDTH  address of the first word; sampled with start.
- row_len  in  ROW_LEN_SIZE  words per row; sampled with start.
- num_rows  in  ROW_LEN_SIZE  rows per tile; sampled with start.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_ren  out  1  memory read strobe; data returns exactly 1 cycle later.
- mem_rdata  in  DATA_WIDTH  memory read data.
- buf_ready  in  1  FIFO can accept a word this cycle.
- IFMap_in  out  DATA_WIDTH+2  tagged word. Bit [DATA_WIDTH+1] = start-of-row, bit [DATA_WIDTH] = end-of-row.
- wen_IFMap_buffer  out  1  FIFO write strobe.
- busy  out  1  tile in progress.
- done  out  1  one-cycle pulse after the last word of a tile is written.

## Operation
- States:
  - IDLE: on start, latch config and go to RUN. If row_len==0 or num_rows==0, go to DONE instead and write nothing.
  - RUN: issues reads until all row_len*num_rows reads are issued, then goes to DRAIN.
  - DRAIN: waits until in-flight reads and skid occupancy both reach 0, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Address generation:
  - Linear; read k uses base_addr+k.
  - The sum wraps modulo 2^ADDR_WIDTH; no error.
  - Internal column and row counters track the position of each issued read.
- Tag generation:
  - The column/row position travels with each read into the skid entry.
  - Start-of-row tag = (col==0); end-of-row tag = (col==row_len-1).
  - row_len==1 sets both tags on every word.
- Read issue rule: issue in RUN when (skid_count + inflight) < 2, or when it equals 2 and a pop occurs this cycle. This guarantees the skid buffer never overflows.
- Write to the FIFO:
  - wen_IFMap_buffer = (skid_count != 0) && buf_ready.
  - IFMap_in is the skid head, and is held stable while buf_ready is low.
  - The skid buffer is first-in first-out; returned data enters at the tail.
- start while busy: ignored; config is not re-latched.
- rst at any cycle:
  - Returns to IDLE and clears the skid buffer, in-flight tracking and counters.
  - Data returning on mem_rdata the cycle after rst is discarded.

## Timing
- Reset values: mem_addr=0, mem_ren=0, IFMap_in=0, wen_IFMap_buffer=0, busy=0, done=0.
- start sampled at edge t:
  - busy=1 from cycle t+1.
  - First mem_ren in cycle t+1 with mem_addr=base_addr.
  - Data captured at edge t+2.
  - First wen_IFMap_buffer in cycle t+2+1 = t+3 if buf_ready.
- Throughput: with buf_ready held high, one write per cycle. A tile of N words writes in cycles t+3 .. t+N+2. done pulses in cycle t+N+3, and busy falls in that same cycle.
- Empty tile: done in cycle t+1, busy stays 0, and no mem_ren is issued.
- Back-pressure:
  - buf_ready low for k cycles stalls writes for exactly k cycles.
  - At most 2 reads are outstanding-or-buffered; no word is lost or duplicated.
  - Reads resume within 1 cycle of buf_ready rising.
- done and busy are registered outputs. mem_ren and wen_IFMap_buffer are combinational from state and buf_ready.

## Test plan
- row_len=4, num_rows=2, base_addr=0x10, memory[a]=a, buf_ready=1:
  - 8 writes in consecutive cycles, payloads 0x10..0x17.
  - Tags (MSB,next) are 10,00,00,01 per row.
  - done arrives 11 cycles after start.
- Same tile, buf_ready toggling 1,0,0,1,0,1… pseudo-randomly: identical ordered payloads and tags; no writes while buf_ready=0; at most 2 reads outstanding+buffered at any cycle.
- row_len=1, num_rows=3: three writes, each tagged 11.
- row_len=0, num_rows=5: done pulses the cycle after start; zero mem_ren and zero writes.
- base_addr=0xFFFE, row_len=4, num_rows=1: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst asserted mid-tile with buf_ready=0 and 2 words buffered:
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent start produces a clean tile with no stale words.
